// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel magnitude path and the frame aligner downstream.
// mag_lat() is the single source of the input->output latency.
package sobel_pkg;

  localparam int SOBEL_DW = 8;
  localparam int SOBEL_GW = 2 * SOBEL_DW;

  typedef struct packed {
    logic vsync;
    logic hsync;
  } sync_t;

  // abs (1) + square (1) + sum (1) + one stage per root bit (gw) + output register (1)
  function automatic int mag_lat(input int gw);
    return gw + 4;
  endfunction

endpackage

// File: rtl/isqrt_pipe.sv
// Pipelined restoring integer square root: one result bit per stage, MSB first, OUT_W stages.
// A sideband bus rides along unchanged so timing signals stay aligned with the root.
module isqrt_pipe #(
  parameter int IN_W  = 32,
  parameter int OUT_W = IN_W / 2,
  parameter int SB_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  din,
  input  logic [SB_W-1:0]  sb_in,
  output logic [OUT_W-1:0] dout,
  output logic [SB_W-1:0]  sb_out
);

  genvar gi;
  for (gi = 0; gi < OUT_W; gi++) begin : g_stage
    // radicand bits not yet consumed when entering this stage
    localparam int RW = IN_W - 2 * gi;

    logic [RW-1:0]    rad_in;
    logic [OUT_W-1:0] rem_in;
    logic [OUT_W-1:0] root_in;
    logic [SB_W-1:0]  sb_stage_in;
    logic [OUT_W+1:0] rem_sh;
    logic [OUT_W+1:0] trial;
    logic             ge;
    logic [OUT_W-1:0] root_reg;
    logic [SB_W-1:0]  sb_reg;

    if (gi == 0) begin : g_first
      assign rad_in      = din;
      assign rem_in      = '0;
      assign root_in     = '0;
      assign sb_stage_in = sb_in;
    end else begin : g_chain
      assign rad_in      = g_stage[gi-1].g_mid.rad_reg;
      assign rem_in      = g_stage[gi-1].g_mid.rem_reg;
      assign root_in     = g_stage[gi-1].root_reg;
      assign sb_stage_in = g_stage[gi-1].sb_reg;
    end

    assign rem_sh = {rem_in, rad_in[RW-1 -: 2]};
    assign trial  = {root_in, 2'b01};
    assign ge     = (rem_sh >= trial);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        root_reg <= '0;
        sb_reg   <= '0;
      end else begin
        root_reg <= {root_in[OUT_W-2:0], ge};
        sb_reg   <= sb_stage_in;
      end
    end

    // The remainder never exceeds 2*root, so OUT_W bits hold it; the last stage needs none.
    if (gi < OUT_W - 1) begin : g_mid
      logic [OUT_W-1:0] rem_next;
      logic [OUT_W-1:0] rem_reg;
      logic [RW-3:0]    rad_reg;

      assign rem_next = ge ? (rem_sh[OUT_W-1:0] - trial[OUT_W-1:0]) : rem_sh[OUT_W-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_reg <= '0;
          rad_reg <= '0;
        end else begin
          rem_reg <= rem_next;
          rad_reg <= rad_in[RW-3:0];
        end
      end
    end
  end

  assign dout   = g_stage[OUT_W-1].root_reg;
  assign sb_out = g_stage[OUT_W-1].sb_reg;

endmodule

// File: rtl/sobel_grad_magnitude.sv
// L2 gradient magnitude with saturation and per-frame thresholded edge map.
// abs -> square -> sum -> pipelined sqrt -> output register; one pixel per clk, no stalls.
module sobel_grad_magnitude
  import sobel_pkg::*;
#(
  parameter int DW = SOBEL_DW,
  parameter int GW = DW * 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_vsync,
  input  logic          din_hsync,
  input  logic [GW-1:0] din_grad_x,
  input  logic [GW-1:0] din_grad_y,
  input  logic [GW-1:0] thresh,
  output logic          dout_vsync,
  output logic          dout_hsync,
  output logic [DW-1:0] dout_mag,
  output logic          dout_edge,
  output logic [DW-1:0] dout_bin
);

  localparam int SQ_W = 2 * GW;
  localparam int SB_W = GW + 2;
  localparam logic [GW-1:0] MAG_MAX = GW'((2 ** DW) - 1);

  function automatic logic [GW-1:0] abs_val(input logic [GW-1:0] v);
    return v[GW-1] ? (~v + 1'b1) : v;
  endfunction

  logic          vs_prev_reg;
  logic [GW-1:0] thr_reg;
  logic          frame_start;
  logic [GW-1:0] thr_cur;

  // The first pixel of a frame already uses the threshold captured on that same clk.
  assign frame_start = din_vsync & ~vs_prev_reg;
  assign thr_cur     = frame_start ? thresh : thr_reg;

  logic [GW-1:0]   ax_reg, ay_reg, s1_thr_reg;
  sync_t           s1_sync_reg;
  logic [SQ_W-1:0] sqx_reg, sqy_reg;
  logic [GW-1:0]   s2_thr_reg;
  sync_t           s2_sync_reg;
  logic [SQ_W-1:0] sum_reg;
  logic [GW-1:0]   s3_thr_reg;
  sync_t           s3_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_reg <= 1'b0;
      thr_reg     <= '0;
      ax_reg      <= '0;
      ay_reg      <= '0;
      s1_thr_reg  <= '0;
      s1_sync_reg <= '0;
      sqx_reg     <= '0;
      sqy_reg     <= '0;
      s2_thr_reg  <= '0;
      s2_sync_reg <= '0;
      sum_reg     <= '0;
      s3_thr_reg  <= '0;
      s3_sync_reg <= '0;
    end else begin
      vs_prev_reg <= din_vsync;
      thr_reg     <= thr_cur;
      ax_reg      <= abs_val(din_grad_x);
      ay_reg      <= abs_val(din_grad_y);
      s1_thr_reg  <= thr_cur;
      s1_sync_reg <= '{vsync: din_vsync, hsync: din_hsync};
      sqx_reg     <= SQ_W'(ax_reg) * SQ_W'(ax_reg);
      sqy_reg     <= SQ_W'(ay_reg) * SQ_W'(ay_reg);
      s2_thr_reg  <= s1_thr_reg;
      s2_sync_reg <= s1_sync_reg;
      sum_reg     <= sqx_reg + sqy_reg;
      s3_thr_reg  <= s2_thr_reg;
      s3_sync_reg <= s2_sync_reg;
    end
  end

  logic [GW-1:0]   root;
  logic [SB_W-1:0] sb_out;
  sync_t           root_sync;
  logic [GW-1:0]   root_thr;

  isqrt_pipe #(
    .IN_W  (SQ_W),
    .OUT_W (GW),
    .SB_W  (SB_W)
  ) u_isqrt (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (sum_reg),
    .sb_in  ({s3_sync_reg, s3_thr_reg}),
    .dout   (root),
    .sb_out (sb_out)
  );

  assign {root_sync, root_thr} = sb_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_vsync <= 1'b0;
      dout_hsync <= 1'b0;
      dout_mag   <= '0;
      dout_edge  <= 1'b0;
    end else begin
      dout_vsync <= root_sync.vsync;
      dout_hsync <= root_sync.hsync;
      dout_mag   <= !root_sync.hsync ? '0
                  : (root > MAG_MAX) ? MAG_MAX[DW-1:0] : root[DW-1:0];
      dout_edge  <= root_sync.hsync & (root > root_thr);
    end
  end

  assign dout_bin = {DW{dout_edge}};

endmodule

// File: tb/tb_sobel_grad_magnitude.sv
// Directed vectors plus streaming sequences for sobel_grad_magnitude; expected values are
// hand-computed or come from a behavioural floor-sqrt reference.
module tb_sobel_grad_magnitude;
  import sobel_pkg::*;

  localparam int DW  = 8;
  localparam int GW  = 16;
  localparam int LAT = mag_lat(GW);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din_vsync = 1'b0;
  logic          din_hsync = 1'b0;
  logic [GW-1:0] din_grad_x = '0;
  logic [GW-1:0] din_grad_y = '0;
  logic [GW-1:0] thresh = '0;
  logic          dout_vsync, dout_hsync, dout_edge;
  logic [DW-1:0] dout_mag, dout_bin;

  sobel_grad_magnitude #(.DW(DW), .GW(GW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_vsync  (din_vsync),
    .din_hsync  (din_hsync),
    .din_grad_x (din_grad_x),
    .din_grad_y (din_grad_y),
    .thresh     (thresh),
    .dout_vsync (dout_vsync),
    .dout_hsync (dout_hsync),
    .dout_mag   (dout_mag),
    .dout_edge  (dout_edge),
    .dout_bin   (dout_bin)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct {
    int gx;
    int gy;
    int th;
    int exp_mag;
    bit exp_edge;
  } vec_t;

  typedef struct packed {
    logic          vs;
    logic          hs;
    logic [DW-1:0] mag;
    logic          e;
    logic [DW-1:0] bin;
  } out_t;

  out_t exp_q[$];
  int   cyc = 0;
  bit   m_vs_prev = 1'b0;
  int   m_thr = 0;

  function automatic int fsqrt(input longint unsigned s);
    int unsigned r = 0;
    for (int b = 15; b >= 0; b--) begin
      longint unsigned c = longint'(r | (32'd1 << b));
      if (c * c <= s) r = int'(c);
    end
    return int'(r);
  endfunction

  // One streaming clk: check the output that is due, then drive the next input.
  task automatic tick(input bit vs, input bit hs, input int x, input int y, input int th,
                      input int emag, input bit eedge);
    out_t got, e;
    @(negedge clk);
    cyc++;
    if (exp_q.size() == LAT) begin
      e   = exp_q.pop_front();
      got = '{vs: dout_vsync, hs: dout_hsync, mag: dout_mag, e: dout_edge, bin: dout_bin};
      n_total++;
      if (got == e) n_pass++;
      else $display("FAIL stream cyc %0d: got vs=%0d hs=%0d mag=%0d edge=%0d bin=%0h, expected vs=%0d hs=%0d mag=%0d edge=%0d bin=%0h",
                    cyc, got.vs, got.hs, got.mag, got.e, got.bin, e.vs, e.hs, e.mag, e.e, e.bin);
    end
    din_vsync  = vs;
    din_hsync  = hs;
    din_grad_x = GW'(x);
    din_grad_y = GW'(y);
    thresh     = GW'(th);
    e.vs  = vs;
    e.hs  = hs;
    e.mag = hs ? DW'(emag) : '0;
    e.e   = hs & eedge;
    e.bin = {DW{e.e}};
    exp_q.push_back(e);
  endtask

  task automatic model_tick(input bit vs, input bit hs, input int x, input int y, input int th);
    int r;
    if (vs && !m_vs_prev) m_thr = th;
    m_vs_prev = vs;
    r = fsqrt(longint'(x * x + y * y));
    tick(vs, hs, x, y, th, (r > 255) ? 255 : r, r > m_thr);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    din_vsync = 1'b0; din_hsync = 1'b0;
    @(negedge clk);
    din_vsync = 1'b1; din_hsync = 1'b1;
    din_grad_x = GW'(v.gx); din_grad_y = GW'(v.gy); thresh = GW'(v.th);
    @(negedge clk);
    din_vsync = 1'b0; din_hsync = 1'b0; din_grad_x = '0; din_grad_y = '0;
    repeat (LAT - 2) @(negedge clk);
    check($sformatf("vec%0d early_hsync", idx), dout_hsync, 0);
    @(negedge clk);
    check($sformatf("vec%0d hsync", idx), dout_hsync, 1);
    check($sformatf("vec%0d vsync", idx), dout_vsync, 1);
    check($sformatf("vec%0d mag", idx), dout_mag, v.exp_mag);
    check($sformatf("vec%0d edge", idx), dout_edge, v.exp_edge);
    check($sformatf("vec%0d bin", idx), dout_bin, v.exp_edge ? 255 : 0);
  endtask

  vec_t vecs[14];
  bit   pat[5];

  initial begin
    vecs[0]  = '{3, 4, 4, 5, 1};
    vecs[1]  = '{-1020, 0, 2000, 255, 0};
    vecs[2]  = '{-32768, -32768, 46339, 255, 1};
    vecs[3]  = '{-32768, -32768, 46340, 255, 0};
    vecs[4]  = '{0, 0, 0, 0, 0};
    vecs[5]  = '{12, 5, 13, 13, 0};
    vecs[6]  = '{12, 5, 12, 13, 1};
    vecs[7]  = '{255, 0, 0, 255, 1};
    vecs[8]  = '{256, 0, 255, 255, 1};
    vecs[9]  = '{15, -8, 16, 17, 1};
    vecs[10] = '{1, 1, 0, 1, 1};
    vecs[11] = '{100, 100, 141, 141, 0};
    vecs[12] = '{32767, 0, 32766, 255, 1};
    vecs[13] = '{-3, 3, 3, 4, 1};
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("reset vsync", dout_vsync, 0);
    check("reset hsync", dout_hsync, 0);
    check("reset mag", dout_mag, 0);
    check("reset edge", dout_edge, 0);
    check("reset bin", dout_bin, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // flush to idle, then start the scoreboard with an all-idle pipeline
    repeat (LAT) @(negedge clk);
    for (int i = 0; i < LAT; i++) exp_q.push_back('0);

    // threshold changes mid-frame only apply from the next frame
    tick(1'b0, 1'b0, 0, 0, 10, 0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 50, 0, (i < 10) ? 10 : 100, 50, 1'b1);
    tick(1'b0, 1'b0, 0, 0, 100, 0, 1'b0);
    for (int i = 0; i < 30; i++) tick(1'b1, 1'b1, 50, 0, 100, 50, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 0, 0, 100, 0, 1'b0);
    m_vs_prev = 1'b0;

    // 640-pixel lines, gapped hsync, back-to-back frames with 1-clk vsync gap, random data
    for (int f = 0; f < 2; f++) begin
      model_tick(1'b0, 1'b0, 0, 0, $urandom_range(0, 400));
      for (int ln = 0; ln < 2; ln++) begin
        for (int p = 0; p < 640; p++)
          model_tick(1'b1, pat[p % 5], int'($urandom_range(0, 600)) - 300,
                     int'($urandom_range(0, 600)) - 300, $urandom_range(0, 400));
        for (int g = 0; g < 4; g++) model_tick(1'b1, 1'b0, 0, 0, $urandom_range(0, 400));
      end
    end
    for (int i = 0; i < LAT; i++) model_tick(1'b0, 1'b0, 0, 0, 0);

    // asynchronous reset mid-line with a pipeline full of valid pixels
    for (int i = 0; i < 25; i++) model_tick(1'b1, 1'b1, 200 + i, 7, 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst vsync", dout_vsync, 0);
    check("async_rst hsync", dout_hsync, 0);
    check("async_rst mag", dout_mag, 0);
    check("async_rst edge", dout_edge, 0);
    exp_q.delete();
    din_vsync = 1'b0; din_hsync = 1'b0; din_grad_x = '0; din_grad_y = '0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    begin
      int stale = 0;
      for (int i = 0; i < LAT + 4; i++) begin
        @(negedge clk);
        if (dout_hsync || dout_vsync || dout_mag != 0) stale++;
      end
      check("post_rst stale outputs", stale, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
